// File: rtl/recv_program_fsm_pkg.sv
// Shared constants for the program loader: default UART/instruction/address
// widths, the default HALT word, and a small width helper.
package recv_program_fsm_pkg;

  localparam int unsigned UART_BITS_DEFAULT        = 8;
  localparam int unsigned INSTRUCTION_BITS_DEFAULT = 32;
  localparam int unsigned INST_ADDRS_BITS_DEFAULT  = 8;
  localparam logic [31:0] HALT_INSTRUCTION_DEFAULT = 32'hFFFF_FFFF;

  // Number of UART bytes that make up one instruction word.
  function automatic int unsigned bytes_per_word(input int unsigned inst_bits,
                                                 input int unsigned uart_bits);
    return inst_bits / uart_bits;
  endfunction

endpackage

// File: rtl/recv_program_fsm_rx_done_edge.sv
// Registered rising-edge detector for the UART byte-valid flag; a held level
// produces a single-cycle rise.
module rx_done_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise_c
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= level;
  end

  assign rise_c = level & ~prev;

endmodule

// File: rtl/recv_program_fsm.sv
// Loads a program from a UART byte stream into instruction memory, packing
// bytes MSB-first into words until a HALT word or the last address is written.
module recv_program_fsm
  import recv_program_fsm_pkg::*;
#(
  parameter int unsigned UART_BITS        = UART_BITS_DEFAULT,
  parameter int unsigned INSTRUCTION_BITS = INSTRUCTION_BITS_DEFAULT,
  parameter int unsigned INST_ADDRS_BITS  = INST_ADDRS_BITS_DEFAULT,
  parameter logic [INSTRUCTION_BITS-1:0] HALT_INSTRUCTION =
    INSTRUCTION_BITS'(HALT_INSTRUCTION_DEFAULT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic                        i_rx_done,
  input  logic [UART_BITS-1:0]        i_rx_data,
  output logic                        o_inst_we,
  output logic [INST_ADDRS_BITS-1:0]  o_inst_address,
  output logic [INSTRUCTION_BITS-1:0] o_inst_data,
  output logic                        o_done,
  output logic                        o_full,
  output logic [3:0]                  o_state
);

  localparam int unsigned BYTES = bytes_per_word(INSTRUCTION_BITS, UART_BITS);
  localparam int unsigned CNT_W = $clog2(BYTES + 1);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    WAIT_BYTE  = 4'd1,
    WRITE_INST = 4'd2,
    FINISH     = 4'd3
  } state_t;

  state_t                      state, state_n;
  logic [INST_ADDRS_BITS-1:0]  addr, addr_n;
  logic [CNT_W-1:0]            cnt, cnt_n;
  logic [INSTRUCTION_BITS-1:0] word, word_n;
  logic                        full_n;
  logic                        we_q, done_q, full_q;
  logic                        rx_rise_c;

  rx_done_edge u_rx_done_edge (
    .clk    (clk),
    .rst    (rst),
    .level  (i_rx_done),
    .rise_c (rx_rise_c)
  );

  // State, datapath and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr   <= '0;
      cnt    <= '0;
      word   <= '0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      full_q <= 1'b0;
    end else begin
      state  <= state_n;
      addr   <= addr_n;
      cnt    <= cnt_n;
      word   <= word_n;
      we_q   <= (state_n == WRITE_INST);
      done_q <= (state_n == FINISH);
      full_q <= full_n;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_n = state;
    addr_n  = addr;
    cnt_n   = cnt;
    word_n  = word;
    full_n  = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_n = WAIT_BYTE;
          addr_n  = '0;
          cnt_n   = '0;
          word_n  = '0;
        end
      end
      WAIT_BYTE: begin
        if (rx_rise_c) begin
          word_n = (word << UART_BITS) | INSTRUCTION_BITS'(i_rx_data);
          cnt_n  = cnt + CNT_W'(1);
          if (cnt == CNT_W'(BYTES - 1)) state_n = WRITE_INST;
        end
      end
      WRITE_INST: begin
        // HALT takes priority so a HALT at the last address is not flagged full.
        if (word == HALT_INSTRUCTION) begin
          state_n = FINISH;
        end else if (addr == '1) begin
          state_n = FINISH;
          full_n  = 1'b1;
        end else begin
          state_n = WAIT_BYTE;
          addr_n  = addr + INST_ADDRS_BITS'(1);
          cnt_n   = '0;
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign o_inst_we      = we_q;
  assign o_inst_address = addr;
  assign o_inst_data    = word;
  assign o_done         = done_q;
  assign o_full         = full_q;
  assign o_state        = state;

endmodule

// File: tb/tb_recv_program_fsm.sv
// Directed bench for recv_program_fsm: a default-width instance and a 2-bit
// address instance share one stimulus stream; writes and done pulses are logged.
module tb_recv_program_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rx_done;
  logic [7:0]  rx_data;

  logic        we, done, full;
  logic [7:0]  addr;
  logic [31:0] data;
  logic [3:0]  state;

  logic        we_s, done_s, full_s;
  logic [1:0]  addr_s;
  logic [31:0] data_s;
  logic [3:0]  state_s;

  int vectors = 0;
  int errs    = 0;

  logic [39:0] wq[$];
  logic [33:0] wqs[$];
  int          done_cnt, done_cnt_s;
  logic        last_full, last_full_s;

  always #5 clk = ~clk;

  recv_program_fsm dut (
    .clk(clk), .rst(rst), .i_start(start), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .o_inst_we(we), .o_inst_address(addr), .o_inst_data(data),
    .o_done(done), .o_full(full), .o_state(state)
  );

  recv_program_fsm #(.INST_ADDRS_BITS(2)) dut_s (
    .clk(clk), .rst(rst), .i_start(start), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .o_inst_we(we_s), .o_inst_address(addr_s), .o_inst_data(data_s),
    .o_done(done_s), .o_full(full_s), .o_state(state_s)
  );

  // Write / done logger, sampled mid-cycle.
  always @(negedge clk) begin
    if (we)     wq.push_back({addr, data});
    if (we_s)   wqs.push_back({addr_s, data_s});
    if (done)   begin done_cnt++;   last_full   = full;   end
    if (done_s) begin done_cnt_s++; last_full_s = full_s; end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic start_load();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    rx_data = b;
    rx_done = 1'b1;
    repeat (hold) tick();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int hold);
    send_byte(w[31:24], hold);
    send_byte(w[23:16], hold);
    send_byte(w[15:8],  hold);
    send_byte(w[7:0],   hold);
  endtask

  task automatic clear_log();
    wq.delete();
    wqs.delete();
    done_cnt    = 0;
    done_cnt_s  = 0;
    last_full   = 1'bx;
    last_full_s = 1'bx;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
    clear_log();

    // Reset state
    idle(2);
    check("rst_we",    64'(we),    64'(0));
    check("rst_addr",  64'(addr),  64'(0));
    check("rst_data",  64'(data),  64'(0));
    check("rst_done",  64'(done),  64'(0));
    check("rst_full",  64'(full),  64'(0));
    check("rst_state", 64'(state), 64'(0));
    rst = 1'b0;
    idle(1);

    // Basic load, single-cycle byte strobes
    clear_log();
    start_load();
    check("basic_state_wait", 64'(state), 64'(1));
    send_word(32'h1234_5678, 1);
    send_word(32'hFFFF_FFFF, 1);
    idle(5);
    check("basic_nwr",   64'(wq.size()), 64'(2));
    check("basic_wr0",   64'(wq[0]),     64'({8'd0, 32'h1234_5678}));
    check("basic_wr1",   64'(wq[1]),     64'({8'd1, 32'hFFFF_FFFF}));
    check("basic_done",  64'(done_cnt),  64'(1));
    check("basic_full",  64'(last_full), 64'(0));
    check("basic_idle",  64'(state),     64'(0));
    check("basic_s_nwr", 64'(wqs.size()), 64'(2));
    check("basic_s_wr1", 64'(wqs[1]),    64'({2'd1, 32'hFFFF_FFFF}));

    // Held level: each byte strobe high for 5 cycles
    clear_log();
    start_load();
    send_word(32'h1234_5678, 5);
    send_word(32'hFFFF_FFFF, 5);
    idle(5);
    check("held_nwr",  64'(wq.size()), 64'(2));
    check("held_wr0",  64'(wq[0]),     64'({8'd0, 32'h1234_5678}));
    check("held_wr1",  64'(wq[1]),     64'({8'd1, 32'hFFFF_FFFF}));
    check("held_done", 64'(done_cnt),  64'(1));
    check("held_full", 64'(last_full), 64'(0));

    // Memory full on the 2-bit address instance; fifth word ignored there
    clear_log();
    start_load();
    send_word(32'h0102_0304, 1);
    send_word(32'h1112_1314, 1);
    send_word(32'h2122_2324, 1);
    send_word(32'h3132_3334, 1);
    idle(3);
    send_word(32'h4142_4344, 1);
    idle(5);
    check("full_nwr",    64'(wqs.size()),  64'(4));
    check("full_wr0",    64'(wqs[0]),      64'({2'd0, 32'h0102_0304}));
    check("full_wr2",    64'(wqs[2]),      64'({2'd2, 32'h2122_2324}));
    check("full_wr3",    64'(wqs[3]),      64'({2'd3, 32'h3132_3334}));
    check("full_done",   64'(done_cnt_s),  64'(1));
    check("full_flag",   64'(last_full_s), 64'(1));
    check("full_idle",   64'(state_s),     64'(0));
    check("wide_nwr",    64'(wq.size()),   64'(5));
    check("wide_wr4",    64'(wq[4]),       64'({8'd4, 32'h4142_4344}));
    check("wide_nodone", 64'(done_cnt),    64'(0));
    check("wide_wait",   64'(state),       64'(1));
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);

    // Reset mid-load aborts; next load restarts at address 0
    clear_log();
    start_load();
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("mid_state", 64'(state), 64'(0));
    check("mid_addr",  64'(addr),  64'(0));
    check("mid_data",  64'(data),  64'(0));
    idle(2);
    check("mid_nowr",  64'(wq.size()), 64'(0));
    start_load();
    send_word(32'hAABB_CCDD, 1);
    send_word(32'hFFFF_FFFF, 1);
    idle(5);
    check("mid_nwr",  64'(wq.size()), 64'(2));
    check("mid_wr0",  64'(wq[0]),     64'({8'd0, 32'hAABB_CCDD}));
    check("mid_wr1",  64'(wq[1]),     64'({8'd1, 32'hFFFF_FFFF}));
    check("mid_done", 64'(done_cnt),  64'(1));

    // Write latency, spurious start/strobe in WRITE_INST, discards in FINISH/IDLE
    clear_log();
    start_load();
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    send_byte(8'h33, 1);
    rx_data = 8'h44;
    rx_done = 1'b1;
    check("lat_pre_we", 64'(we), 64'(0));
    tick();
    check("lat_we",    64'(we),    64'(1));
    check("lat_addr",  64'(addr),  64'(0));
    check("lat_data",  64'(data),  64'(32'h1122_3344));
    check("lat_state", 64'(state), 64'(2));
    start   = 1'b1;
    rx_data = 8'h99;
    tick();
    start   = 1'b0;
    rx_done = 1'b0;
    check("spur_we",    64'(we),    64'(0));
    check("spur_state", 64'(state), 64'(1));
    check("spur_addr",  64'(addr),  64'(1));
    tick();
    send_word(32'h5566_7788, 1);
    send_byte(8'hFF, 1);
    send_byte(8'hFF, 1);
    send_byte(8'hFF, 1);
    rx_data = 8'hFF;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
    check("fin_done",  64'(done),  64'(1));
    check("fin_full",  64'(full),  64'(0));
    check("fin_state", 64'(state), 64'(3));
    rx_data = 8'hEE;
    rx_done = 1'b1;
    tick();
    check("fin_exit_state", 64'(state), 64'(0));
    check("fin_exit_done",  64'(done),  64'(0));
    rx_done = 1'b0;
    tick();
    send_byte(8'h77, 1);
    check("idle_stay", 64'(state), 64'(0));
    start_load();
    send_word(32'h0102_0304, 1);
    send_word(32'hFFFF_FFFF, 1);
    idle(5);
    check("spur_nwr",  64'(wq.size()), 64'(5));
    check("spur_wr0",  64'(wq[0]),     64'({8'd0, 32'h1122_3344}));
    check("spur_wr1",  64'(wq[1]),     64'({8'd1, 32'h5566_7788}));
    check("spur_wr2",  64'(wq[2]),     64'({8'd2, 32'hFFFF_FFFF}));
    check("spur_wr3",  64'(wq[3]),     64'({8'd0, 32'h0102_0304}));
    check("spur_wr4",  64'(wq[4]),     64'({8'd1, 32'hFFFF_FFFF}));
    check("spur_done", 64'(done_cnt),  64'(2));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
